chunked_adder: RTL and testbench

//  Parametrised multi-cycle adder/subtractor, successor of the 1-bit FullAdder.

---
 rtl/chunked_adder_if.sv | 25 ++
 rtl/chunked_adder.sv | 128 ++++++++++++
 tb/tb_chunked_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/chunked_adder_if.sv
// rtl/chunked_adder_if.sv - request/result bundle between a client and the chunked adder
interface chunked_adder_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output start, a, b, cin, sub,
        input  busy, done, sum, carry, overflow
    );

    modport slave (
        input  start, a, b, cin, sub,
        output busy, done, sum, carry, overflow
    );
endinterface

// File: rtl/chunked_adder.sv
// rtl/chunked_adder.sv - multi-cycle adder/subtractor, CHUNK bits per clock with a registered carry
module chunked_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic          clk,
    input  logic          rst,
    chunked_adder_if.slave bus
);
    localparam int NCH = WIDTH / CHUNK;
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic             creg_q, creg_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] a_sh, b_sh, work_new;
    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic [CHUNK:0]   sl_res;
    logic             sl_c, msb_cin, last, accept;
    int               sh;

    always_comb begin
        sh       = int'(idx_q) * CHUNK;
        a_sh     = op_a_q >> sh;
        b_sh     = op_b_q >> sh;
        sl_a     = a_sh[CHUNK-1:0];
        sl_b     = b_sh[CHUNK-1:0];
        sl_res   = {1'b0, sl_a} + {1'b0, sl_b} + {{CHUNK{1'b0}}, creg_q};
        sl_s     = sl_res[CHUNK-1:0];
        sl_c     = sl_res[CHUNK];
        // sum bit = a ^ b ^ carry-in, so the carry into the slice MSB falls out of an XOR
        msb_cin  = sl_s[CHUNK-1] ^ sl_a[CHUNK-1] ^ sl_b[CHUNK-1];
        work_new = (work_q & ~(WIDTH'({CHUNK{1'b1}}) << sh)) | (WIDTH'(sl_s) << sh);
        last     = (idx_q == IW'(NCH - 1));
        accept   = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        creg_d  = creg_q;
        work_d  = work_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    op_a_d  = bus.a;
                    op_b_d  = bus.sub ? ~bus.b : bus.b;
                    creg_d  = bus.sub ? 1'b1 : bus.cin;
                    idx_d   = '0;
                    work_d  = '0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                work_d = work_new;
                creg_d = sl_c;
                if (last) begin
                    sum_d   = work_new;
                    carry_d = sl_c;
                    ovf_d   = msb_cin ^ sl_c;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            creg_q  <= 1'b0;
            work_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            creg_q  <= creg_d;
            work_q  <= work_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.sum      = sum_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_chunked_adder.sv
// tb/tb_chunked_adder.sv - directed self-checking bench for chunked_adder
module tb_chunked_adder;
    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   errs    = 0;

    always #5 clk = ~clk;

    chunked_adder_if #(.WIDTH(16)) bus ();
    chunked_adder_if #(.WIDTH(16)) bus6 ();

    chunked_adder #(.WIDTH(16), .CHUNK(4))  dut  (.clk(clk), .rst(rst), .bus(bus.slave));
    chunked_adder #(.WIDTH(16), .CHUNK(16)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.sub = sub;
        bus.start = 1'b1;
    endtask

    // full operation: accept, four busy cycles, one-cycle done pulse
    task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub,
                         input logic [15:0] es, input logic ec, input logic ev);
        drive(a, b, cin, sub);
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
            chk({tag, "_nodone"}, 32'(bus.done), 32'd0);
            step();
        end
        chk({tag, "_done"}, 32'(bus.done), 32'd1);
        chk({tag, "_busy_low"}, 32'(bus.busy), 32'd0);
        chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
        chk({tag, "_carry"}, 32'(bus.carry), 32'(ec));
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'(ev));
        step();
        chk({tag, "_pulse_end"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
        bus6.start = 1'b0; bus6.a = '0; bus6.b = '0; bus6.cin = 1'b0; bus6.sub = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'h0);
        chk("rst_carry", 32'(bus.carry), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        step();

        do_op("t1_ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("t2_7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("t2_cin", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        do_op("t3_5m7", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("t3_5m7_cin", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op("t3_8000m1", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // start pulse during RUN is ignored, operands change too
        drive(16'h0001, 16'h0002, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        step();
        bus.start = 1'b0;
        chk("t4_sum_held", 32'(bus.sum), 32'h7FFF);
        chk("t4_still_busy", 32'(bus.busy), 32'd1);
        step();
        step();
        chk("t4_done", 32'(bus.done), 32'd1);
        chk("t4_sum", 32'(bus.sum), 32'h0003);
        chk("t4_carry", 32'(bus.carry), 32'd0);
        drive(16'h0010, 16'h0020, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        chk("t4_b2b_busy", 32'(bus.busy), 32'd1);
        chk("t4_b2b_nodone", 32'(bus.done), 32'd0);
        step(); step(); step(); step();
        chk("t4_b2b_done", 32'(bus.done), 32'd1);
        chk("t4_b2b_sum", 32'(bus.sum), 32'h0030);
        step();

        // reset on second RUN cycle aborts without a done pulse
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        step();
        bus.start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_busy", 32'(bus.busy), 32'd0);
        chk("t5_done", 32'(bus.done), 32'd0);
        chk("t5_sum", 32'(bus.sum), 32'h0);
        chk("t5_carry", 32'(bus.carry), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t5_no_pulse", 32'(bus.done), 32'd0);
        end
        do_op("t5_fresh", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

        // single-slice instance
        bus6.a = 16'h0001; bus6.b = 16'h0002; bus6.cin = 1'b1; bus6.sub = 1'b0;
        bus6.start = 1'b1;
        step();
        bus6.start = 1'b0;
        chk("t6_busy", 32'(bus6.busy), 32'd1);
        chk("t6_nodone", 32'(bus6.done), 32'd0);
        step();
        chk("t6_done", 32'(bus6.done), 32'd1);
        chk("t6_sum", 32'(bus6.sum), 32'h0004);
        chk("t6_carry", 32'(bus6.carry), 32'd0);
        step();
        chk("t6_pulse_end", 32'(bus6.done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
